// File: rtl/midi_parser_pkg.sv
// Shared constants and types for the MIDI channel-voice parser.
package midi_parser_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned DATA_W = 7;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned CHAN_W = 4;

  typedef enum logic [1:0] {
    ST_NOSTAT  = 2'd0,
    ST_WAIT_D1 = 2'd1,
    ST_WAIT_D2 = 2'd2,
    ST_SYSEX   = 2'd3
  } state_t;

  localparam logic [NIB_W-1:0] NIB_NOTE_OFF = 4'h8;
  localparam logic [NIB_W-1:0] NIB_NOTE_ON  = 4'h9;
  localparam logic [NIB_W-1:0] NIB_POLY_AT  = 4'hA;
  localparam logic [NIB_W-1:0] NIB_CTRL     = 4'hB;
  localparam logic [NIB_W-1:0] NIB_PROG     = 4'hC;
  localparam logic [NIB_W-1:0] NIB_CHAN_AT  = 4'hD;
  localparam logic [NIB_W-1:0] NIB_BEND     = 4'hE;

  localparam logic [BYTE_W-1:0] SYSEX_START = 8'hF0;
  localparam logic [BYTE_W-1:0] SYSEX_END   = 8'hF7;
  localparam logic [BYTE_W-1:0] RT_MIN      = 8'hF8;

  // Program change and channel pressure carry one data byte; the rest carry two.
  function automatic logic msg_two_bytes(input logic [NIB_W-1:0] nib);
    return !((nib == NIB_PROG) || (nib == NIB_CHAN_AT));
  endfunction

endpackage

// File: rtl/midi_parser.sv
// Byte-stream MIDI parser: decodes note/pressure events with running status,
// skipping SysEx and realtime bytes.
module midi_parser
  import midi_parser_pkg::*;
(
  input  logic                clk32,
  input  logic                rst,
  input  logic [BYTE_W-1:0]   rx_data,
  input  logic                rx_valid,
  output logic                note_pressed,
  output logic                note_released,
  output logic                note_keypress,
  output logic                note_channelpress,
  output logic [DATA_W-1:0]   note_interface,
  output logic [DATA_W-1:0]   velocity,
  output logic [CHAN_W-1:0]   channel,
  output logic                parse_err
);

  state_t              state, state_nxt;
  logic [BYTE_W-1:0]   status, status_nxt;
  logic [DATA_W-1:0]   d1, d1_nxt;
  logic                pressed_nxt, released_nxt, keypress_nxt, chanpress_nxt, err_nxt;
  logic [DATA_W-1:0]   note_nxt, vel_nxt;
  logic [CHAN_W-1:0]   chan_nxt;
  logic                done;
  logic [DATA_W-1:0]   msg_d1, msg_d2;

  // State, running status and all outputs are registered together.
  always_ff @(posedge clk32 or negedge rst) begin
    if (!rst) begin
      state             <= ST_NOSTAT;
      status            <= '0;
      d1                <= '0;
      note_pressed      <= 1'b0;
      note_released     <= 1'b0;
      note_keypress     <= 1'b0;
      note_channelpress <= 1'b0;
      parse_err         <= 1'b0;
      note_interface    <= '0;
      velocity          <= '0;
      channel           <= '0;
    end else begin
      state             <= state_nxt;
      status            <= status_nxt;
      d1                <= d1_nxt;
      note_pressed      <= pressed_nxt;
      note_released     <= released_nxt;
      note_keypress     <= keypress_nxt;
      note_channelpress <= chanpress_nxt;
      parse_err         <= err_nxt;
      note_interface    <= note_nxt;
      velocity          <= vel_nxt;
      channel           <= chan_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    status_nxt    = status;
    d1_nxt        = d1;
    pressed_nxt   = 1'b0;
    released_nxt  = 1'b0;
    keypress_nxt  = 1'b0;
    chanpress_nxt = 1'b0;
    err_nxt       = 1'b0;
    note_nxt      = note_interface;
    vel_nxt       = velocity;
    chan_nxt      = channel;
    done          = 1'b0;
    msg_d1        = '0;
    msg_d2        = '0;

    if (rx_valid) begin
      if (rx_data >= RT_MIN) begin
        // Realtime bytes are transparent to the parser.
      end else if (rx_data == SYSEX_START) begin
        state_nxt  = ST_SYSEX;
        status_nxt = '0;
      end else if (rx_data > SYSEX_START) begin
        // System common (including SysEx end) drops running status.
        state_nxt  = ST_NOSTAT;
        status_nxt = '0;
      end else if (rx_data[BYTE_W-1]) begin
        state_nxt  = ST_WAIT_D1;
        status_nxt = rx_data;
      end else begin
        case (state)
          ST_NOSTAT: err_nxt = 1'b1;
          ST_WAIT_D1: begin
            d1_nxt = rx_data[DATA_W-1:0];
            if (msg_two_bytes(status[BYTE_W-1 -: NIB_W])) begin
              state_nxt = ST_WAIT_D2;
            end else begin
              done   = 1'b1;
              msg_d1 = rx_data[DATA_W-1:0];
            end
          end
          ST_WAIT_D2: begin
            state_nxt = ST_WAIT_D1;
            done      = 1'b1;
            msg_d1    = d1;
            msg_d2    = rx_data[DATA_W-1:0];
          end
          default: ;
        endcase
      end
    end

    // Map the completed message onto the event outputs.
    if (done) begin
      case (status[BYTE_W-1 -: NIB_W])
        NIB_NOTE_OFF: begin
          released_nxt = 1'b1;
          note_nxt     = msg_d1;
          vel_nxt      = msg_d2;
          chan_nxt     = status[CHAN_W-1:0];
        end
        NIB_NOTE_ON: begin
          pressed_nxt  = (msg_d2 != '0);
          released_nxt = (msg_d2 == '0);
          note_nxt     = msg_d1;
          vel_nxt      = msg_d2;
          chan_nxt     = status[CHAN_W-1:0];
        end
        NIB_POLY_AT: begin
          keypress_nxt = 1'b1;
          note_nxt     = msg_d1;
          vel_nxt      = msg_d2;
          chan_nxt     = status[CHAN_W-1:0];
        end
        NIB_CHAN_AT: begin
          chanpress_nxt = 1'b1;
          note_nxt      = '0;
          vel_nxt       = msg_d1;
          chan_nxt      = status[CHAN_W-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule
